// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector, holds it for DWELL
// cycles, and checks the DUT output against EXPECTED on the last dwell cycle.
module truth_table_sweeper #(
  parameter int                     N_IN     = 3,
  parameter int                     DWELL    = 25,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = 8'b1001_0110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            mode_loop,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   mis_q, mis_d;
  logic            fail_q, fail_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            loop_q, loop_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mis_q   <= '0;
      fail_q  <= 1'b0;
      first_q <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    fail_d  = fail_q;
    first_d = first_q;
    loop_d  = loop_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          cnt_d   = '0;
          mis_d   = '0;
          fail_d  = 1'b0;
          first_d = '0;
          loop_d  = mode_loop;
        end
      end
      RUN: begin
        // abort wins over a coinciding sample, so that vector is never scored
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          vec_d = vec_q + 1'b1;
          if (dut_out != EXPECTED[vec_q]) begin
            if (mis_q != '1) mis_d = mis_q + 1'b1;
            if (!fail_q) begin
              fail_d  = 1'b1;
              first_d = vec_q;
            end
          end
          // last vector: increment above already wraps dut_in to 0
          if (vec_q == '1) begin
            done_d = 1'b1;
            if (!loop_q) state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dut_in         = vec_q;
  assign busy           = (state_q == RUN);
  assign done           = done_q;
  assign mismatch_cnt   = mis_q;
  assign fail_seen      = fail_q;
  assign first_fail_idx = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: randomized sweeps against a parity reference,
// with a scoreboard of expected done events and per-cycle vector tracking.
module tb_truth_table_sweeper;

  localparam int DW = 4;
  localparam int NV = 8;
  localparam int SW = NV * DW;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mode_loop = 1'b0;
  logic       dut_out;
  logic [2:0] dut_in;
  logic       busy;
  logic       done;
  logic [3:0] mismatch_cnt;
  logic       fail_seen;
  logic [2:0] first_fail_idx;

  logic [7:0] act_tbl = 8'h00;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  bit exp_run = 1'b0;
  int exp_T = 0;
  int exp_end = 0;

  int m_cnt = 0;
  bit m_fail = 1'b0;
  int m_first = 0;

  typedef struct {
    int cyc;
    int cnt;
    int fail;
    int first;
  } exp_t;
  exp_t sbq[$];

  truth_table_sweeper #(
    .N_IN    (3),
    .DWELL   (DW),
    .EXPECTED(8'b1001_0110)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .mode_loop     (mode_loop),
    .dut_out       (dut_out),
    .dut_in        (dut_in),
    .busy          (busy),
    .done          (done),
    .mismatch_cnt  (mismatch_cnt),
    .fail_seen     (fail_seen),
    .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural combinational DUT: a lookup table indexed by the applied vector
  assign dut_out = act_tbl[dut_in];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a correct DUT computes odd parity of its inputs
  task automatic model_sweep(input logic [7:0] tbl, input int nvec,
                             inout int cnt, inout bit fail, inout int first);
    logic [2:0] kv;
    for (int k = 0; k < nvec; k++) begin
      kv = 3'(k);
      if (tbl[k] != (^kv)) begin
        if (cnt < 15) cnt++;
        if (!fail) begin
          fail  = 1'b1;
          first = k;
        end
      end
    end
  endtask

  task automatic push_done(input int c);
    exp_t e;
    e.cyc = c; e.cnt = m_cnt; e.fail = int'(m_fail); e.first = m_first;
    sbq.push_back(e);
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_cnt"}, mismatch_cnt, m_cnt);
    chk({tag, "_fail"}, fail_seen, m_fail);
    if (m_fail) chk({tag, "_first"}, first_fail_idx, m_first);
  endtask

  task automatic do_start(input bit loop, input bit with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    mode_loop = loop;
    exp_T = cyc + 1;
    exp_end = loop ? 32'h7fff_ffff : exp_T + SW;
    exp_run = 1'b1;
    m_cnt = 0; m_fail = 1'b0; m_first = 0;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    mode_loop = 1'($urandom % 2);
    check_results("start_clear");
  endtask

  task automatic run_single(input logic [7:0] tbl, input bit spurious, input bit with_abort);
    act_tbl = tbl;
    do_start(1'b0, with_abort);
    model_sweep(act_tbl, NV, m_cnt, m_fail, m_first);
    push_done(exp_T + SW);
    for (int i = 1; i < SW + 2; i++) begin
      @(negedge clk);
      if (spurious && i == 13) begin
        start = 1'b1;
        mode_loop = ~mode_loop;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_after_done", busy, 0);
    check_results("single");
  endtask

  // Monitor: tracks expected vector/busy per cycle and pops the scoreboard on done
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_run && !rst && cyc >= exp_T) begin
      if (cyc < exp_end) begin
        chk("busy_run", busy, 1);
        chk("dut_in_run", dut_in, ((cyc - exp_T) / DW) % NV);
      end else begin
        chk("busy_idle", busy, 0);
        chk("dut_in_idle", dut_in, 0);
      end
    end
    if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        e = sbq.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_cnt", mismatch_cnt, e.cnt);
        chk("done_fail", fail_seen, e.fail);
        if (e.fail != 0) chk("done_first", first_fail_idx, e.first);
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
      chk("missing_done", done, 1);
      void'(sbq.pop_front());
    end
  end

  initial begin
    logic [7:0] rtbl;
    int gap;

    #2 rst = 1'b1;
    #1;
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", mismatch_cnt, 0);
    chk("rst_fail", fail_seen, 0);
    chk("rst_first", first_fail_idx, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Correct parity DUT, then stuck-at-0 with a spurious start at vector 3
    run_single(8'b1001_0110, 1'b0, 1'b0);
    run_single(8'h00, 1'b1, 1'b0);

    // Inverted parity, loop mode, two full sweeps then abort
    act_tbl = 8'b0110_1001;
    do_start(1'b1, 1'b0);
    model_sweep(act_tbl, NV, m_cnt, m_fail, m_first);
    push_done(exp_T + SW);
    model_sweep(act_tbl, NV, m_cnt, m_fail, m_first);
    push_done(exp_T + 2 * SW);
    repeat (2 * SW + 1) @(negedge clk);
    chk("loop_busy", busy, 1);
    abort = 1'b1;
    exp_end = cyc + 1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check_results("loop_abort");

    // Stuck-at-0, abort on the sample edge of vector 2
    act_tbl = 8'h00;
    do_start(1'b0, 1'b0);
    repeat (3 * DW - 1) @(negedge clk);
    abort = 1'b1;
    exp_end = exp_T + 3 * DW;
    model_sweep(act_tbl, 2, m_cnt, m_fail, m_first);
    @(negedge clk);
    abort = 1'b0;
    repeat (SW) @(negedge clk);
    check_results("abort");

    // abort while idle changes nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check_results("idle_abort");
    chk("idle_abort_busy", busy, 0);

    // Asynchronous reset in the middle of vector 5
    act_tbl = 8'h00;
    do_start(1'b0, 1'b0);
    repeat (5 * DW + 1) @(negedge clk);
    model_sweep(act_tbl, 5, m_cnt, m_fail, m_first);
    check_results("pre_rst");
    #2;
    exp_run = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_dut_in", dut_in, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt", mismatch_cnt, 0);
    chk("arst_fail", fail_seen, 0);
    chk("arst_first", first_fail_idx, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_single(8'b1001_0110, 1'b0, 1'b0);

    // Randomized sweeps with random faulty tables
    repeat (6) begin
      rtbl = 8'($urandom);
      run_single(rtbl, 1'($urandom % 2), 1'($urandom % 2));
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
